// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 master bridge.
//   apb_state_e : bridge sequencing states (IDLE, SETUP, ACCESS, RESP)
//   apb_cmd_t   : one native command record at the default 32/32 configuration
//   APB_PROT_W  : width of the APB4 protection field
`timescale 1ns/1ps
package apb_pkg;

    localparam int APB_PROT_W = 3;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic [APB_PROT_W-1:0] prot;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge.sv
// APB4 initiator: converts native valid/ready commands into single APB4
// transfers (SETUP then ACCESS, honouring PREADY wait states) and returns
// read data / error status on a valid/ready response channel.
// Only one transfer is outstanding at a time.
//
// Ports
//   pclk, preset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_addr/write/wdata/strb/prot  command payload, latched on handshake
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           read data (0 for writes), slave error/timeout
//   paddr/pprot/pwrite/pwdata/pstrb  APB4 address/control/data (registered)
//   psel, penable                APB4 select/enable
//   prdata, pready, pslverr      APB4 completer response
//
// Build option
//   APB_MASTER_TIMEOUT_EN : when defined, an ACCESS phase that sees no pready
//   for TIMEOUT_CYCLES cycles is aborted and answered with rsp_err=1,
//   rsp_rdata=0. When undefined, ACCESS waits indefinitely.
`timescale 1ns/1ps
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [APB_PROT_W-1:0]   cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [APB_PROT_W-1:0]   pprot,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    psel,
    output logic                    penable,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    // Reject configurations the byte-strobe and watchdog logic cannot express.
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master_bridge: illegal parameter combination");
    end

    apb_state_e state;
    apb_state_e state_next;
    logic       timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOUT_W-1:0] tout_cnt;

    // Counts ACCESS cycles that ended without pready; the count equals the
    // number of completed wait cycles, so the limit is reached on the
    // TIMEOUT_CYCLES-th ACCESS cycle. A pready on that cycle still wins.
    always_ff @(posedge pclk) begin
        if (preset || state == SETUP) begin
            tout_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            tout_cnt <= tout_cnt + TOUT_W'(1);
        end
    end

    assign timeout_hit = (state == ACCESS) && !pready &&
                         (tout_cnt == TOUT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/select decode. cmd_ready is also held low
    // while reset is asserted so no command is taken during reset.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !preset;
                if (cmd_valid && !preset) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // APB payload is loaded on command acceptance and then simply held, which
    // keeps it stable through SETUP/ACCESS and leaves the last values visible
    // afterwards. Reads drive zero data and zero strobes onto the bus.
    // The response is captured on the completing ACCESS cycle.
    always_ff @(posedge pclk) begin
        if (preset) begin
            paddr     <= '0;
            pprot     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                paddr  <= cmd_addr;
                pprot  <= cmd_prot;
                pwrite <= cmd_write;
                pwdata <= cmd_write ? cmd_wdata : '0;
                pstrb  <= cmd_write ? cmd_strb : '0;
            end
            if (state == ACCESS) begin
                if (pready) begin
                    rsp_rdata <= pwrite ? '0 : prdata;
                    rsp_err   <= pslverr;
                end else if (timeout_hit) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

endmodule
